// File: rtl/pipelined_register_file.sv
// Multi-port GPR file for the pipelined MIPS datapath: bypassed reads, two
// prioritised write ports, busy scoreboard and a register dump streamer.
module pipelined_register_file #(
    parameter int ADDR_WIDTH = 5,
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 32,
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] RA,
    output logic [NUM_RD*WIDTH-1:0]      RD,
    output logic [NUM_RD-1:0]            SB_BUSY,
    input  logic                         WE0,
    input  logic [ADDR_WIDTH-1:0]        WA0,
    input  logic [WIDTH-1:0]             WD0,
    input  logic                         WE1,
    input  logic [ADDR_WIDTH-1:0]        WA1,
    input  logic [WIDTH-1:0]             WD1,
    input  logic                         SB_SET,
    input  logic [ADDR_WIDTH-1:0]        SB_ADDR,
    input  logic                         DUMP_REQ,
    output logic                         DUMP_VALID,
    input  logic                         DUMP_READY,
    output logic [ADDR_WIDTH-1:0]        DUMP_ADDR,
    output logic [WIDTH-1:0]             DUMP_DATA,
    output logic                         DUMP_LAST,
    output logic                         DUMP_ACTIVE,
    output logic                         DBG_STATE
);

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} dump_state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    logic [WIDTH-1:0]      regs_q [DEPTH];
    logic [WIDTH-1:0]      regs_d [DEPTH];
    logic [DEPTH-1:0]      busy_q, busy_d;
    dump_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  wr0_ok, wr1_ok, sb_ok;

    assign wr0_ok = WE0 && in_range(WA0) && !is_zero(WA0);
    assign wr1_ok = WE1 && in_range(WA1) && !is_zero(WA1);
    assign sb_ok  = SB_SET && in_range(SB_ADDR) && !is_zero(SB_ADDR);

    // Port 1 is applied last so it wins a same-address collision.
    always_comb begin
        regs_d = regs_q;
        if (wr0_ok) regs_d[WA0] = WD0;
        if (wr1_ok) regs_d[WA1] = WD1;
    end

    // Clears first, then the set, so a set beats a same-cycle clear.
    always_comb begin
        busy_d = busy_q;
        if (wr0_ok) busy_d[WA0] = 1'b0;
        if (wr1_ok) busy_d[WA1] = 1'b0;
        if (sb_ok)  busy_d[SB_ADDR] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [WIDTH-1:0]      rd;
        assign ra = RA[k*ADDR_WIDTH +: ADDR_WIDTH];
        always_comb begin
            if (!in_range(ra) || is_zero(ra))             rd = '0;
            else if ((BYPASS != 0) && WE1 && (WA1 == ra)) rd = WD1;
            else if ((BYPASS != 0) && WE0 && (WA0 == ra)) rd = WD0;
            else                                          rd = regs_q[ra];
        end
        assign RD[k*WIDTH +: WIDTH] = rd;
        assign SB_BUSY[k]           = in_range(ra) ? busy_q[ra] : 1'b0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (DUMP_REQ) begin
                    state_d = STREAM;
                    ptr_d   = '0;
                end
            end
            STREAM: begin
                if (DUMP_READY) begin
                    if (ptr_q == LAST_IDX) state_d = IDLE;
                    else                   ptr_d   = ptr_q + ADDR_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Dump data reads the stored array, so a write in the handshake cycle
    // transfers the old value and a write during a stall shows up next cycle.
    always_comb begin
        DUMP_VALID  = 1'b0;
        DUMP_ACTIVE = 1'b0;
        DUMP_LAST   = 1'b0;
        DUMP_ADDR   = ptr_q;
        DUMP_DATA   = '0;
        if (state_q == STREAM) begin
            DUMP_VALID  = 1'b1;
            DUMP_ACTIVE = 1'b1;
            DUMP_LAST   = (ptr_q == LAST_IDX);
            if (!is_zero(ptr_q)) DUMP_DATA = regs_q[ptr_q];
        end
    end

    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_pipelined_register_file.sv
// Directed bench for pipelined_register_file: reads, bypass, write priority,
// R0 handling, scoreboard, and the dump stream with stalls and reset abort.
module tb_pipelined_register_file;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [9:0]  RA = '0;
    logic        WE0 = 1'b0, WE1 = 1'b0, SB_SET = 1'b0;
    logic [4:0]  WA0 = '0, WA1 = '0, SB_ADDR = '0;
    logic [31:0] WD0 = '0, WD1 = '0;
    logic        DUMP_REQ = 1'b0, DUMP_READY = 1'b0;

    logic [63:0] rd, rd_nz;
    logic [1:0]  sb_busy, sb_busy_nz;
    logic        dump_valid, dump_last, dump_active, dbg_state;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;
    logic        nz_valid, nz_last, nz_active, nz_state;
    logic [4:0]  nz_addr;
    logic [31:0] nz_data;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    always #5 CLK = ~CLK;

    pipelined_register_file dut (
        .CLK(CLK), .RST(RST), .RA(RA), .RD(rd), .SB_BUSY(sb_busy),
        .WE0(WE0), .WA0(WA0), .WD0(WD0), .WE1(WE1), .WA1(WA1), .WD1(WD1),
        .SB_SET(SB_SET), .SB_ADDR(SB_ADDR), .DUMP_REQ(DUMP_REQ),
        .DUMP_VALID(dump_valid), .DUMP_READY(DUMP_READY), .DUMP_ADDR(dump_addr),
        .DUMP_DATA(dump_data), .DUMP_LAST(dump_last), .DUMP_ACTIVE(dump_active),
        .DBG_STATE(dbg_state)
    );

    // Same inputs, but R0 behaves as an ordinary register.
    pipelined_register_file #(.ZERO_REG(0)) dut_nz (
        .CLK(CLK), .RST(RST), .RA(RA), .RD(rd_nz), .SB_BUSY(sb_busy_nz),
        .WE0(WE0), .WA0(WA0), .WD0(WD0), .WE1(WE1), .WA1(WA1), .WD1(WD1),
        .SB_SET(SB_SET), .SB_ADDR(SB_ADDR), .DUMP_REQ(DUMP_REQ),
        .DUMP_VALID(nz_valid), .DUMP_READY(DUMP_READY), .DUMP_ADDR(nz_addr),
        .DUMP_DATA(nz_data), .DUMP_LAST(nz_last), .DUMP_ACTIVE(nz_active),
        .DBG_STATE(nz_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        WE0 = 1'b0; WE1 = 1'b0; SB_SET = 1'b0; DUMP_REQ = 1'b0;
    endtask

    initial begin
        int beats;
        int cyc;
        int exp_addr;
        logic wrote, wrote_now;

        // Reset state
        repeat (2) tick();
        check("rst_valid", 32'(dump_valid), 32'd0);
        check("rst_active", 32'(dump_active), 32'd0);
        check("rst_last", 32'(dump_last), 32'd0);
        RST = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) begin
            RA[4:0] = 5'(i);
            RA[9:5] = 5'(31 - i);
            #1;
            check("rst_rd0", rd[31:0], 32'd0);
            check("rst_rd1", rd[63:32], 32'd0);
            check("rst_busy", 32'(sb_busy), 32'd0);
        end
        check("rst_dump_valid", 32'(dump_valid), 32'd0);

        // Basic write then read, with same-cycle bypass on port 1
        WE0 = 1'b1; WA0 = 5'd5; WD0 = 32'hDEADBEEF; RA[9:5] = 5'd5; RA[4:0] = 5'd6;
        #1;
        check("bypass_wd0", rd[63:32], 32'hDEADBEEF);
        check("no_bypass_other", rd[31:0], 32'd0);
        tick();
        idle_inputs();
        RA[4:0] = 5'd5;
        #1;
        check("stored_r5", rd[31:0], 32'hDEADBEEF);

        // Dual write collision: port 1 wins, bypass too
        WE0 = 1'b1; WA0 = 5'd7; WD0 = 32'h11;
        WE1 = 1'b1; WA1 = 5'd7; WD1 = 32'h22;
        RA[4:0] = 5'd7;
        #1;
        check("collide_bypass", rd[31:0], 32'h22);
        tick();
        idle_inputs();
        #1;
        check("collide_stored", rd[31:0], 32'h22);

        // R0 writes: dropped with ZERO_REG=1, kept with ZERO_REG=0
        WE1 = 1'b1; WA1 = 5'd0; WD1 = 32'hFFFFFFFF; RA[4:0] = 5'd0;
        #1;
        check("r0_bypass_zero", rd[31:0], 32'd0);
        check("r0_bypass_nz", rd_nz[31:0], 32'hFFFFFFFF);
        tick();
        idle_inputs();
        #1;
        check("r0_stored_zero", rd[31:0], 32'd0);
        check("r0_stored_nz", rd_nz[31:0], 32'hFFFFFFFF);

        // Scoreboard set, set-beats-clear, clear; no bypass on busy
        SB_SET = 1'b1; SB_ADDR = 5'd3; RA[4:0] = 5'd3;
        #1;
        check("sb_no_bypass", 32'(sb_busy[0]), 32'd0);
        tick();
        idle_inputs();
        #1;
        check("sb_set", 32'(sb_busy[0]), 32'd1);
        WE0 = 1'b1; WA0 = 5'd3; WD0 = 32'h33; SB_SET = 1'b1; SB_ADDR = 5'd3;
        tick();
        idle_inputs();
        #1;
        check("sb_set_wins", 32'(sb_busy[0]), 32'd1);
        WE0 = 1'b1; WA0 = 5'd3; WD0 = 32'h34;
        tick();
        idle_inputs();
        #1;
        check("sb_cleared", 32'(sb_busy[0]), 32'd0);
        SB_SET = 1'b1; SB_ADDR = 5'd0; RA[4:0] = 5'd0;
        tick();
        idle_inputs();
        #1;
        check("sb_r0_zero", 32'(sb_busy[0]), 32'd0);
        check("sb_r0_nz", 32'(sb_busy_nz[0]), 32'd1);

        // Preload Rn = n + 0x100
        for (int n = 0; n < 32; n++) begin
            WE0 = 1'b1; WA0 = 5'(n); WD0 = 32'(n) + 32'h100;
            tick();
        end
        idle_inputs();

        // Full dump with READY held high
        DUMP_READY = 1'b1;
        DUMP_REQ = 1'b1;
        #1;
        check("dump_not_yet_active", 32'(dump_active), 32'd0);
        tick();
        DUMP_REQ = 1'b0;
        for (int b = 0; b < 32; b++) begin
            check("dump_valid", 32'(dump_valid), 32'd1);
            check("dump_active", 32'(dump_active), 32'd1);
            check("dump_addr", 32'(dump_addr), 32'(b));
            check("dump_data", dump_data, (b == 0) ? 32'd0 : 32'(b) + 32'h100);
            check("dump_last", 32'(dump_last), (b == 31) ? 32'd1 : 32'd0);
            tick();
        end
        check("dump_done_valid", 32'(dump_valid), 32'd0);
        check("dump_done_active", 32'(dump_active), 32'd0);

        // Dump with READY pattern 1,0,0,1, a stalled write, then reset at beat 10
        exp_q.delete();
        for (int n = 0; n < 32; n++) exp_q.push_back((n == 0) ? 32'd0 : 32'(n) + 32'h100);
        DUMP_READY = 1'b0;
        DUMP_REQ = 1'b1;
        tick();
        DUMP_REQ = 1'b0;
        beats = 0; cyc = 0; exp_addr = 0; wrote = 1'b0;
        while (beats < 10 && cyc < 200) begin
            DUMP_READY = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            WE0 = 1'b0;
            wrote_now = 1'b0;
            if (!DUMP_READY && exp_addr == 5 && !wrote) begin
                WE0 = 1'b1; WA0 = 5'd5; WD0 = 32'h5555;
                wrote = 1'b1; wrote_now = 1'b1;
            end
            #1;
            check("stall_valid", 32'(dump_valid), 32'd1);
            check("stall_addr", 32'(dump_addr), 32'(exp_addr));
            check("stall_data", dump_data, exp_q[0]);
            if (DUMP_READY) begin
                void'(exp_q.pop_front());
                exp_addr++;
                beats++;
            end
            tick();
            if (wrote_now) exp_q[0] = 32'h5555;
            cyc++;
        end
        check("stall_no_timeout", 32'(beats), 32'd10);
        check("stall_wrote_r5", 32'(wrote), 32'd1);
        idle_inputs();
        RST = 1'b0;
        RA[4:0] = 5'd5; RA[9:5] = 5'd7;
        #1;
        check("abort_valid", 32'(dump_valid), 32'd0);
        check("abort_active", 32'(dump_active), 32'd0);
        check("abort_r5", rd[31:0], 32'd0);
        check("abort_r7", rd[63:32], 32'd0);
        DUMP_READY = 1'b1;
        tick();
        RST = 1'b1;
        repeat (3) tick();
        check("post_abort_valid", 32'(dump_valid), 32'd0);
        check("post_abort_r5", rd[31:0], 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
